multicycle_datapath: RTL and testbench

//  Multi-cycle, parametrised successor of the 16-bit single-cycle datapath. Accepts one decoded

---
 rtl/multicycle_datapath.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multi-cycle datapath with register file, ALU, shift-add multiplier and data memory
// One decoded instruction per handshake, sequenced through IDLE/READ/EXEC/MEM/WB or the MULT loop.
module multicycle_datapath #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int MEM_AW = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [DATA_W-1:0] imm,
  input  logic              reg_dst,
  input  logic              alu_src,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              reg_write,
  input  logic              mult,
  input  logic              branch,
  input  logic [2:0]        alu_control,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              branch_taken,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_MULT = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [DATA_W-1:0]   rf_q [2**REG_AW];
  logic [DATA_W-1:0]   mem_q [2**MEM_AW];

  logic [REG_AW-1:0]   rs_q, rt_q, dst_q;
  logic [DATA_W-1:0]   imm_q;
  logic [2:0]          alu_ctl_q;
  logic                alu_src_q, mr_q, mw_q, m2r_q, rw_q, mult_q, br_q;

  logic [DATA_W-1:0]   a_q, b_q, alu_q, mdr_q, result_q, hi_q, lo_q;
  logic                done_q, zero_q, branch_taken_q;
  logic [2*DATA_W-1:0] prod_q;
  logic [CW-1:0]       cnt_q;

  logic [DATA_W-1:0]   rd_a, rd_b, opb, alu_y, wb_val;
  logic [DATA_W:0]     msum;
  logic [MEM_AW-1:0]   mem_addr;

  assign rd_a     = (rs_q == '0) ? '0 : rf_q[rs_q];
  assign rd_b     = (rt_q == '0) ? '0 : rf_q[rt_q];
  assign opb      = alu_src_q ? imm_q : b_q;
  assign mem_addr = alu_q[MEM_AW-1:0];
  assign msum     = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign wb_val   = mult_q ? prod_q[DATA_W-1:0] : ((mr_q && m2r_q) ? mdr_q : alu_q);

  always_comb begin
    alu_y = '0;
    case (alu_ctl_q)
      3'b000:  alu_y = a_q & opb;
      3'b001:  alu_y = a_q | opb;
      3'b010:  alu_y = a_q + opb;
      3'b011:  alu_y = a_q ^ opb;
      3'b100:  alu_y = ~(a_q | opb);
      3'b110:  alu_y = a_q - opb;
      3'b111:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(opb))};
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (instr_valid) state_d = S_READ;
      S_READ:  state_d = mult_q ? S_MULT : S_EXEC;
      S_EXEC:  state_d = (mr_q || mw_q) ? S_MEM : S_WB;
      S_MEM:   state_d = mr_q ? S_WB : S_IDLE;
      S_WB:    state_d = S_IDLE;
      S_MULT:  if (cnt_q == CNT_LAST) state_d = S_WB;
      default: state_d = S_IDLE;
    endcase
  end

  // mult/branch/store suppress the weaker side effects at capture time
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      for (int i = 0; i < 2**REG_AW; i++) rf_q[i] <= '0;
      rs_q           <= '0;
      rt_q           <= '0;
      dst_q          <= '0;
      imm_q          <= '0;
      alu_ctl_q      <= '0;
      alu_src_q      <= 1'b0;
      mr_q           <= 1'b0;
      mw_q           <= 1'b0;
      m2r_q          <= 1'b0;
      rw_q           <= 1'b0;
      mult_q         <= 1'b0;
      br_q           <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      alu_q          <= '0;
      mdr_q          <= '0;
      result_q       <= '0;
      hi_q           <= '0;
      lo_q           <= '0;
      done_q         <= 1'b0;
      zero_q         <= 1'b0;
      branch_taken_q <= 1'b0;
      prod_q         <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      done_q         <= 1'b0;
      branch_taken_q <= 1'b0;
      case (state_q)
        S_IDLE: if (instr_valid) begin
          rs_q      <= rs_addr;
          rt_q      <= rt_addr;
          dst_q     <= reg_dst ? rd_addr : rt_addr;
          imm_q     <= imm;
          alu_ctl_q <= alu_control;
          alu_src_q <= alu_src;
          m2r_q     <= mem_to_reg;
          mult_q    <= mult;
          br_q      <= branch & ~mult;
          mw_q      <= mem_write & ~mult & ~branch;
          mr_q      <= mem_read & ~mem_write & ~mult & ~branch;
          rw_q      <= reg_write & ~mem_write & ~mult & ~branch;
        end
        S_READ: begin
          a_q   <= rd_a;
          b_q   <= rd_b;
          cnt_q <= '0;
        end
        S_EXEC: begin
          alu_q  <= alu_y;
          zero_q <= (alu_y == '0);
        end
        S_MEM: begin
          mdr_q <= mem_q[mem_addr];
          if (!mr_q) begin
            done_q   <= 1'b1;
            result_q <= alu_q;
          end
        end
        S_MULT: begin
          if (cnt_q == '0) prod_q <= {{DATA_W{1'b0}}, b_q};
          else             prod_q <= {msum, prod_q[DATA_W-1:1]};
          cnt_q <= cnt_q + 1'b1;
        end
        S_WB: begin
          done_q         <= 1'b1;
          result_q       <= wb_val;
          branch_taken_q <= br_q & zero_q;
          if (mult_q) begin
            hi_q <= prod_q[2*DATA_W-1:DATA_W];
            lo_q <= prod_q[DATA_W-1:0];
          end else if (rw_q && dst_q != '0) begin
            rf_q[dst_q] <= wb_val;
          end
        end
        default: ;
      endcase
    end
  end

  // memory is never cleared; the reset gate keeps an aborted store from committing
  always_ff @(posedge clock) begin
    if (!reset && state_q == S_MEM && mw_q) mem_q[mem_addr] <= b_q;
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign done         = done_q;
  assign result       = result_q;
  assign zero         = zero_q;
  assign branch_taken = branch_taken_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - scoreboard bench for multicycle_datapath
// Driver pushes hand-computed expectations; a negedge monitor pops them on each done pulse.
module tb_multicycle_datapath;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0;
  logic [15:0] imm = '0;
  logic        reg_dst = 0, alu_src = 0, mem_read = 0, mem_write = 0;
  logic        mem_to_reg = 0, reg_write = 0, mult = 0, branch = 0;
  logic [2:0]  alu_control = '0;
  logic        done, zero, branch_taken;
  logic [15:0] result, hi, lo;

  localparam logic [7:0] F_RD = 8'h80, F_IMM = 8'h40, F_MR = 8'h20, F_MW = 8'h10;
  localparam logic [7:0] F_M2R = 8'h08, F_RW = 8'h04, F_MUL = 8'h02, F_BR = 8'h01;
  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010, OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100, OP_101 = 3'b101, OP_SUB = 3'b110, OP_SLT = 3'b111;
  localparam logic [2:0] M_R = 3'b001, M_Z = 3'b010, M_HL = 3'b100, M_RZ = 3'b011;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        z;
    logic        bt;
    logic [2:0]  mask;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  multicycle_datapath dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .imm(imm),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mult(mult), .branch(branch),
    .alu_control(alu_control), .done(done), .result(result), .zero(zero),
    .branch_taken(branch_taken), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] res, input logic z, input logic bt,
                              input logic [15:0] ehi, input logic [15:0] elo,
                              input logic [2:0] mask, input int lat);
    exp_t e;
    e.name = ""; e.res = res; e.z = z; e.bt = bt; e.hi = ehi; e.lo = elo;
    e.mask = mask; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk({e.name, "_latency"}, cyc - e.acc, e.lat);
        chk({e.name, "_branch_taken"}, {31'd0, branch_taken}, {31'd0, e.bt});
        if (e.mask[0]) chk({e.name, "_result"}, {16'd0, result}, {16'd0, e.res});
        if (e.mask[1]) chk({e.name, "_zero"}, {31'd0, zero}, {31'd0, e.z});
        if (e.mask[2]) begin
          chk({e.name, "_hi"}, {16'd0, hi}, {16'd0, e.hi});
          chk({e.name, "_lo"}, {16'd0, lo}, {16'd0, e.lo});
        end
      end
    end
  end

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && n < 40);
    if (!done) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run(input string nm, input logic [3:0] rs, input logic [3:0] rt,
                     input logic [3:0] rd, input logic [15:0] imm_v, input logic [2:0] ctl,
                     input logic [7:0] fl, input exp_t e, input int hold);
    chk({nm, "_ready"}, {31'd0, instr_ready}, 32'd1);
    rs_addr = rs; rt_addr = rt; rd_addr = rd; imm = imm_v; alu_control = ctl;
    {reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, mult, branch} = fl;
    instr_valid = 1'b1;
    @(posedge clock);
    #1;
    e.name = nm;
    e.acc  = cyc;
    sb.push_back(e);
    if (hold > 0) begin
      rs_addr = '0; rt_addr = '0; imm = 16'h1234; alu_control = OP_XOR;
      repeat (hold) @(posedge clock);
      #1;
    end
    instr_valid = 1'b0;
    {reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, mult, branch} = '0;
    wait_done(nm);
  endtask

  initial begin
    int nd;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_branch_taken", {31'd0, branch_taken}, 32'd0);
    chk("rst_hi", {16'd0, hi}, 32'd0);
    chk("rst_lo", {16'd0, lo}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run("addi_r1", 0, 1, 0, 16'd5, OP_ADD, F_IMM | F_RW, mk(16'd5, 0, 0, 0, 0, M_RZ, 3), 0);
    run("addi_r2", 0, 2, 0, 16'd7, OP_ADD, F_IMM | F_RW, mk(16'd7, 0, 0, 0, 0, M_RZ, 3), 0);
    run("add_r3", 1, 2, 3, 16'd0, OP_ADD, F_RD | F_RW, mk(16'd12, 0, 0, 0, 0, M_RZ, 3), 2);

    run("beq_taken", 1, 1, 1, 16'd0, OP_SUB, F_RD | F_RW | F_BR, mk(16'd0, 1, 1, 0, 0, M_RZ, 3), 0);
    run("beq_not", 2, 1, 0, 16'd0, OP_SUB, F_BR, mk(16'd2, 0, 0, 0, 0, M_RZ, 3), 0);
    run("r1_kept", 1, 0, 5, 16'd0, OP_ADD, F_IMM | F_RD | F_RW, mk(16'd5, 0, 0, 0, 0, M_RZ, 3), 0);

    run("store", 0, 3, 0, 16'h01FF, OP_ADD, F_IMM | F_MW | F_RW, mk(16'd0, 0, 0, 0, 0, M_Z, 3), 0);
    run("load", 0, 4, 0, 16'h00FF, OP_ADD, F_IMM | F_MR | F_M2R | F_RW, mk(16'd12, 0, 0, 0, 0, M_R, 4), 0);
    run("r4_chk", 4, 0, 6, 16'd0, OP_ADD, F_IMM | F_RD | F_RW, mk(16'd12, 0, 0, 0, 0, M_RZ, 3), 0);
    run("r3_chk", 3, 0, 7, 16'd0, OP_ADD, F_IMM, mk(16'd12, 0, 0, 0, 0, M_RZ, 3), 0);
    run("load_alu", 0, 12, 0, 16'h00FF, OP_ADD, F_IMM | F_MR | F_RW, mk(16'h00FF, 0, 0, 0, 0, M_R, 4), 0);

    run("addi_r8", 0, 8, 0, 16'hFFFF, OP_ADD, F_IMM | F_RW, mk(16'hFFFF, 0, 0, 0, 0, M_RZ, 3), 0);
    run("and", 1, 2, 0, 16'd0, OP_AND, 8'h00, mk(16'd5, 0, 0, 0, 0, M_RZ, 3), 0);
    run("or", 1, 2, 0, 16'd0, OP_OR, 8'h00, mk(16'd7, 0, 0, 0, 0, M_RZ, 3), 0);
    run("xor", 1, 2, 0, 16'd0, OP_XOR, 8'h00, mk(16'd2, 0, 0, 0, 0, M_RZ, 3), 0);
    run("nor", 1, 2, 0, 16'd0, OP_NOR, 8'h00, mk(16'hFFF8, 0, 0, 0, 0, M_RZ, 3), 0);
    run("sub_neg", 1, 2, 0, 16'd0, OP_SUB, 8'h00, mk(16'hFFFE, 0, 0, 0, 0, M_RZ, 3), 0);
    run("slt", 1, 2, 0, 16'd0, OP_SLT, 8'h00, mk(16'd1, 0, 0, 0, 0, M_RZ, 3), 0);
    run("op101", 1, 2, 0, 16'd0, OP_101, 8'h00, mk(16'd0, 1, 0, 0, 0, M_RZ, 3), 0);
    run("slt_imm", 1, 0, 0, 16'h8000, OP_SLT, F_IMM, mk(16'd0, 1, 0, 0, 0, M_RZ, 3), 0);
    run("slt_neg", 8, 1, 0, 16'd0, OP_SLT, 8'h00, mk(16'd1, 0, 0, 0, 0, M_RZ, 3), 0);
    run("add_wrap", 8, 0, 0, 16'd2, OP_ADD, F_IMM, mk(16'd1, 0, 0, 0, 0, M_RZ, 3), 0);

    run("mult_small", 1, 2, 5, 16'd0, OP_AND, F_MUL | F_RW | F_RD, mk(16'h0023, 0, 0, 16'h0000, 16'h0023, M_R | M_HL, 19), 0);
    run("add_r0", 1, 2, 0, 16'd0, OP_ADD, F_RD | F_RW, mk(16'd12, 0, 0, 0, 0, M_RZ, 3), 0);
    run("read_r0", 0, 0, 0, 16'd0, OP_ADD, 8'h00, mk(16'd0, 1, 0, 0, 0, M_RZ, 3), 0);
    run("mult_big", 8, 8, 0, 16'd0, OP_ADD, F_MUL | F_RW | F_MW, mk(16'h0001, 0, 0, 16'hFFFE, 16'h0001, M_R | M_HL, 19), 0);
    run("r8_kept", 8, 0, 0, 16'd0, OP_ADD, F_IMM, mk(16'hFFFF, 0, 0, 0, 0, M_RZ, 3), 0);

    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    rs_addr = 4'd8; rt_addr = 4'd8; mult = 1'b1; instr_valid = 1'b1;
    @(posedge clock);
    #1;
    instr_valid = 1'b0; mult = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort_hi", {16'd0, hi}, 32'd0);
    chk("abort_lo", {16'd0, lo}, 32'd0);
    chk("abort_ready_after", {31'd0, instr_ready}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    nd = 0;
    repeat (30) begin
      @(negedge clock);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 32'd0);
    run("post_reset_r1", 1, 0, 0, 16'd0, OP_ADD, F_IMM, mk(16'd0, 1, 0, 0, 0, M_RZ, 3), 0);

    repeat (2) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
